// File: rtl/terminate_pipeline.sv
// Terminate micro-op resolver: decides redirect and computes target, one-cycle registered result.
// Optional TERM_FLAG_INDEX_EN: conditional flag bit select taken from flag_index instead of immediate.
module terminate_pipeline #(
  parameter int ADDR_W = 16,
  parameter int FLAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] reg_base_val,
  input  logic [3:0]        flag_index,
  input  logic [FLAG_W-1:0] flag_vals,
  input  logic [7:0]        offset,
  input  logic [3:0]        immediate,
  output logic [ADDR_W-1:0] result_addr,
  output logic              result_valid
);

  localparam int SEL_W = $clog2(FLAG_W);
  localparam logic [3:0] OP_UNCOND = 4'b1111;
  localparam logic [3:0] OP_COND   = 4'b1110;

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              valid_d, valid_q;
  logic [ADDR_W-1:0] offset_ext;
  logic [ADDR_W-1:0] imm_ext;
  logic [SEL_W-1:0]  bit_sel;
  logic              cond;

  assign offset_ext = {{(ADDR_W-8){offset[7]}}, offset};
  assign imm_ext    = {{(ADDR_W-4){1'b0}}, immediate};

`ifdef TERM_FLAG_INDEX_EN
  assign bit_sel = flag_index[SEL_W-1:0];
`else
  assign bit_sel = immediate[SEL_W-1:0];
`endif

  // Only some configurations read flag_index; this keeps the remaining bits visibly consumed.
  logic unused_flag_index;
  assign unused_flag_index = ^flag_index;

  assign cond = flag_vals[bit_sel] ^ immediate[3];

  always_comb begin
    addr_d  = '0;
    valid_d = 1'b0;
    case (opcode)
      OP_UNCOND: begin
        valid_d = 1'b1;
        addr_d  = reg_base_val + imm_ext;
      end
      OP_COND: begin
        if (cond) begin
          valid_d = 1'b1;
          addr_d  = reg_base_val + offset_ext;
        end
      end
      default: begin
        addr_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign result_addr  = addr_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_terminate_pipeline.sv
// Self-checking bench for terminate_pipeline: directed vector table, hand sequences, random vs model.
module tb_terminate_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [15:0] reg_base_val;
  logic [3:0]  flag_index;
  logic [7:0]  flag_vals;
  logic [7:0]  offset;
  logic [3:0]  immediate;
  logic [15:0] result_addr;
  logic        result_valid;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  terminate_pipeline dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .reg_base_val (reg_base_val),
    .flag_index   (flag_index),
    .flag_vals    (flag_vals),
    .offset       (offset),
    .immediate    (immediate),
    .result_addr  (result_addr),
    .result_valid (result_valid)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic [3:0]  opcode;
    logic [15:0] base;
    logic [3:0]  fidx;
    logic [7:0]  flags;
    logic [7:0]  offset;
    logic [3:0]  imm;
    logic [15:0] exp_addr;
    logic        exp_valid;
  } vec_t;

  // Reference model: spec rules with plain integer arithmetic.
  function automatic void model(input logic r, input logic [3:0] op, input logic [15:0] base,
                                input logic [3:0] fidx, input logic [7:0] flags,
                                input logic [7:0] off, input logic [3:0] imm,
                                output logic [15:0] addr, output logic valid);
    int idx, soff, sum;
    bit flag_set;
    addr = 16'h0000;
    valid = 1'b0;
    if (!r) return;
    if (op == 4'd15) begin
      sum = int'(base) + int'(imm);
      addr = 16'(sum % 65536);
      valid = 1'b1;
    end else if (op == 4'd14) begin
`ifdef TERM_FLAG_INDEX_EN
      idx = int'(fidx) % 8;
`else
      idx = int'(imm) % 8;
`endif
      flag_set = ((int'(flags) >> idx) % 2) == 1;
      if (flag_set != (imm >= 4'd8)) begin
        soff = (off >= 8'd128) ? int'(off) - 256 : int'(off);
        sum = int'(base) + soff + 65536;
        addr = 16'(sum % 65536);
        valid = 1'b1;
      end
    end
  endfunction

  task automatic drive(input logic r, input logic [3:0] op, input logic [15:0] base,
                       input logic [3:0] fidx, input logic [7:0] flags,
                       input logic [7:0] off, input logic [3:0] imm);
    rst_n = r; opcode = op; reg_base_val = base; flag_index = fidx;
    flag_vals = flags; offset = off; immediate = imm;
  endtask

  task automatic check(input string name, input logic [15:0] ea, input logic ev);
    tests_run++;
    if (result_addr !== ea || result_valid !== ev) begin
      tests_failed++;
      $display("FAIL %s: got addr=%h valid=%b, expected addr=%h valid=%b",
               name, result_addr, result_valid, ea, ev);
    end else begin
      $display("ok   %s: addr=%h valid=%b", name, result_addr, result_valid);
    end
  endtask

  // Apply one op for one clock, then compare one cycle after it was presented.
  task automatic step(input string name, input logic r, input logic [3:0] op,
                      input logic [15:0] base, input logic [3:0] fidx, input logic [7:0] flags,
                      input logic [7:0] off, input logic [3:0] imm);
    logic [15:0] ea;
    logic ev;
    drive(r, op, base, fidx, flags, off, imm);
    model(r, op, base, fidx, flags, off, imm, ea, ev);
    @(posedge clk);
    #1;
    check(name, ea, ev);
  endtask

  vec_t vecs[$];

  initial begin
    // Directed vectors with hand-derived expectations.
    vecs.push_back('{"rst0",     1'b0, 4'hF, 16'h1234, 4'h0, 8'hFF, 8'h00, 4'h1, 16'h0000, 1'b0});
    vecs.push_back('{"rst1",     1'b0, 4'hF, 16'h1234, 4'h0, 8'hFF, 8'h00, 4'h1, 16'h0000, 1'b0});
    vecs.push_back('{"uncond",   1'b1, 4'hF, 16'h0008, 4'h0, 8'h00, 8'h00, 4'h1, 16'h0009, 1'b1});
    vecs.push_back('{"cond_b1",  1'b1, 4'hE, 16'h0008, 4'h0, 8'h02, 8'h01, 4'h1, 16'h0009, 1'b1});
    vecs.push_back('{"inv_b3",   1'b1, 4'hE, 16'h0009, 4'h0, 8'hF7, 8'h02, 4'hB, 16'h000B, 1'b1});
    vecs.push_back('{"inv_b4",   1'b1, 4'hE, 16'h0009, 4'h0, 8'hF7, 8'h02, 4'hC, 16'h0000, 1'b0});
    vecs.push_back('{"wrap_neg", 1'b1, 4'hE, 16'h0000, 4'h0, 8'h01, 8'hFF, 4'h0, 16'hFFFF, 1'b1});
    vecs.push_back('{"nop",      1'b1, 4'h0, 16'hFFFF, 4'h0, 8'hFF, 8'h7F, 4'h0, 16'h0000, 1'b0});
    vecs.push_back('{"wrap_unc", 1'b1, 4'hF, 16'hFFFF, 4'h0, 8'h00, 8'h00, 4'h1, 16'h0000, 1'b1});
    vecs.push_back('{"unc_imm15",1'b1, 4'hF, 16'hFFF0, 4'h0, 8'h00, 8'h80, 4'hF, 16'hFFFF, 1'b1});
    vecs.push_back('{"cond_-128",1'b1, 4'hE, 16'h0100, 4'h0, 8'h80, 8'h80, 4'h7, 16'h0080, 1'b1});
    vecs.push_back('{"cond_+127",1'b1, 4'hE, 16'hFFF0, 4'h0, 8'h00, 8'h7F, 4'h8, 16'h006F, 1'b1});
    vecs.push_back('{"cond_miss",1'b1, 4'hE, 16'h4000, 4'h0, 8'hFE, 8'h10, 4'h0, 16'h0000, 1'b0});
    vecs.push_back('{"op_1101",  1'b1, 4'hD, 16'h4000, 4'h0, 8'hFF, 8'h10, 4'h1, 16'h0000, 1'b0});
    vecs.push_back('{"rst_prio", 1'b0, 4'hF, 16'h4000, 4'h0, 8'hFF, 8'h10, 4'h1, 16'h0000, 1'b0});

    drive(1'b0, 4'h0, 16'h0, 4'h0, 8'h0, 8'h0, 4'h0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].opcode, vecs[i].base, vecs[i].fidx,
            vecs[i].flags, vecs[i].offset, vecs[i].imm);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].exp_addr, vecs[i].exp_valid);
    end

    // Back-to-back ops: each result exactly one clock later, bubbles not held.
    step("b2b_a", 1'b1, 4'hF, 16'h1000, 4'h0, 8'h00, 8'h00, 4'h5);
    step("b2b_b", 1'b1, 4'h0, 16'h1000, 4'h0, 8'h00, 8'h00, 4'h5);
    step("b2b_c", 1'b1, 4'hE, 16'h2000, 4'h0, 8'h20, 8'hFE, 4'h5);
    step("b2b_d", 1'b1, 4'hF, 16'h3000, 4'h0, 8'h00, 8'h00, 4'h2);
    step("b2b_e", 1'b1, 4'hE, 16'h3000, 4'h0, 8'h00, 8'h05, 4'h2);

    // Randomized ops, with occasional reset, against the model.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      logic r;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (($urandom_range(0, 1) == 1) ? 4'hF : 4'hE);
      r  = ($urandom_range(0, 19) != 0);
      step($sformatf("rnd%0d", n), r, op, 16'($urandom), 4'($urandom), 8'($urandom),
           8'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
